sd_dma: RTL and testbench

DMA engine that moves 32-bit words between the SD data FIFOs and the system memory bus. It sits between the SD register file, which supplies bank, address, length, direction, start and stop and reads back live progress, and the SD data path's RX/TX FIFOs. It issues one single-word memory transaction per FIFO word until the programmed length is exhausted or software stops it.

---
 rtl/sd_dma_pkg.sv | 20 ++
 rtl/sd_dma.sv | 222 ++++++++++++++++++++++
 tb/tb_sd_dma.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dma_pkg.sv
// Shared SD DMA constants: direction encoding, field widths and FSM states.
package sd_dma_pkg;

  localparam int SD_DMA_BANK_W = 4;
  localparam int SD_DMA_ADDR_W = 24;
  localparam int SD_DMA_LEN_W  = 15;
  localparam int SD_DMA_DATA_W = 32;

  localparam logic SD_DMA_DIR_RX = 1'b0;  // RX FIFO -> memory
  localparam logic SD_DMA_DIR_TX = 1'b1;  // memory -> TX FIFO

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_FETCH = 3'd1,
    DMA_WRITE = 3'd2,
    DMA_READ  = 3'd3,
    DMA_PUSH  = 3'd4
  } sd_dma_state_e;

endpackage

// File: rtl/sd_dma.sv
// SD DMA engine: one single-word memory transaction per FIFO word, between the
// SD data FIFOs and the system memory bus. All outputs are registered.
module sd_dma
  import sd_dma_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [SD_DMA_BANK_W-1:0] i_dma_bank,
  input  logic [SD_DMA_ADDR_W-1:0] i_dma_address,
  input  logic [SD_DMA_LEN_W-1:0]  i_dma_length,
  input  logic                     i_load_bank_address,
  input  logic                     i_load_length,
  input  logic                     i_direction,
  input  logic                     i_start,
  input  logic                     i_stop,
  output logic [SD_DMA_BANK_W-1:0] o_dma_bank,
  output logic [SD_DMA_ADDR_W-1:0] o_dma_address,
  output logic [SD_DMA_LEN_W-1:0]  o_dma_left,
  output logic                     o_busy,
  output logic                     o_rx_fifo_pop,
  input  logic                     i_rx_fifo_empty,
  input  logic [SD_DMA_DATA_W-1:0] i_rx_fifo_data,
  output logic                     o_tx_fifo_push,
  input  logic                     i_tx_fifo_full,
  output logic [SD_DMA_DATA_W-1:0] o_tx_fifo_data,
  output logic                     o_mem_request,
  output logic                     o_mem_write,
  output logic [SD_DMA_BANK_W-1:0] o_mem_bank,
  output logic [SD_DMA_ADDR_W-1:0] o_mem_address,
  output logic [SD_DMA_DATA_W-1:0] o_mem_data,
  input  logic                     i_mem_ack,
  input  logic [SD_DMA_DATA_W-1:0] i_mem_data
);

  sd_dma_state_e             state_q, state_d;
  logic [SD_DMA_BANK_W-1:0]  bank_q, bank_d;
  logic [SD_DMA_ADDR_W-1:0]  addr_q, addr_d;
  logic [SD_DMA_LEN_W-1:0]   left_q, left_d;
  logic                      dir_q, dir_d;
  logic                      busy_q, busy_d;
  logic                      stop_pend_q, stop_pend_d;  // stop seen while a bus transaction is owed
  logic                      pop_q, pop_d;
  logic                      push_q, push_d;
  logic                      req_q, req_d;
  logic                      wr_q, wr_d;
  logic [SD_DMA_DATA_W-1:0]  mem_data_q, mem_data_d;
  logic [SD_DMA_DATA_W-1:0]  tx_data_q, tx_data_d;
  logic                      last_word;

  // The word currently in flight is the final one of the transfer.
  assign last_word = (left_q == SD_DMA_LEN_W'(1));

  // Next-state logic for the transfer FSM, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    addr_d      = addr_q;
    left_d      = left_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    stop_pend_d = stop_pend_q;
    pop_d       = 1'b0;
    push_d      = 1'b0;
    req_d       = req_q;
    wr_d        = wr_q;
    mem_data_d  = mem_data_q;
    tx_data_d   = tx_data_q;

    unique case (state_q)
      DMA_IDLE: begin
        stop_pend_d = 1'b0;
        if (i_load_bank_address) begin
          bank_d = i_dma_bank;
          addr_d = i_dma_address;
        end
        if (i_load_length) begin
          left_d = i_dma_length;
        end
        // Stop in the same cycle as start suppresses the start.
        if (i_start && !i_stop && (left_q != '0)) begin
          dir_d  = i_direction;
          busy_d = 1'b1;
          state_d = (i_direction == SD_DMA_DIR_RX) ? DMA_FETCH : DMA_READ;
        end
      end

      DMA_FETCH: begin
        if (i_stop) begin
          busy_d  = 1'b0;
          state_d = DMA_IDLE;
        end else if (!i_rx_fifo_empty) begin
          pop_d      = 1'b1;
          mem_data_d = i_rx_fifo_data;
          state_d    = DMA_WRITE;
        end
      end

      DMA_WRITE: begin
        // The word has already left the RX FIFO, so a stop here still lets
        // this write finish rather than losing it.
        if (i_stop) begin
          stop_pend_d = 1'b1;
        end
        if (!req_q) begin
          req_d = 1'b1;
          wr_d  = 1'b1;
        end else if (i_mem_ack) begin
          req_d  = 1'b0;
          wr_d   = 1'b0;
          addr_d = addr_q + SD_DMA_ADDR_W'(1);
          left_d = left_q - SD_DMA_LEN_W'(1);
          if (last_word || stop_pend_q || i_stop) begin
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = DMA_IDLE;
          end else begin
            state_d = DMA_FETCH;
          end
        end
      end

      DMA_READ: begin
        if (!req_q) begin
          if (i_stop) begin
            busy_d  = 1'b0;
            state_d = DMA_IDLE;
          end else begin
            req_d = 1'b1;
            wr_d  = 1'b0;
          end
        end else begin
          if (i_stop) begin
            stop_pend_d = 1'b1;
          end
          // A stopped read still completes on the bus, but its data is dropped
          // and the address is left pointing at it.
          if (i_mem_ack) begin
            req_d = 1'b0;
            if (stop_pend_q || i_stop) begin
              busy_d      = 1'b0;
              stop_pend_d = 1'b0;
              state_d     = DMA_IDLE;
            end else begin
              tx_data_d = i_mem_data;
              state_d   = DMA_PUSH;
            end
          end
        end
      end

      DMA_PUSH: begin
        if (i_stop) begin
          busy_d  = 1'b0;
          state_d = DMA_IDLE;
        end else if (!i_tx_fifo_full) begin
          push_d = 1'b1;
          addr_d = addr_q + SD_DMA_ADDR_W'(1);
          left_d = left_q - SD_DMA_LEN_W'(1);
          if (last_word) begin
            busy_d  = 1'b0;
            state_d = DMA_IDLE;
          end else begin
            state_d = DMA_READ;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        state_d = DMA_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including data.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= DMA_IDLE;
      bank_q      <= '0;
      addr_q      <= '0;
      left_q      <= '0;
      dir_q       <= SD_DMA_DIR_RX;
      busy_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      pop_q       <= 1'b0;
      push_q      <= 1'b0;
      req_q       <= 1'b0;
      wr_q        <= 1'b0;
      mem_data_q  <= '0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      stop_pend_q <= stop_pend_d;
      pop_q       <= pop_d;
      push_q      <= push_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      mem_data_q  <= mem_data_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign o_dma_bank     = bank_q;
  assign o_dma_address  = addr_q;
  assign o_dma_left     = left_q;
  assign o_busy         = busy_q;
  assign o_rx_fifo_pop  = pop_q;
  assign o_tx_fifo_push = push_q;
  assign o_tx_fifo_data = tx_data_q;
  assign o_mem_request  = req_q;
  assign o_mem_write    = wr_q;
  assign o_mem_bank     = bank_q;
  assign o_mem_address  = addr_q;
  assign o_mem_data     = mem_data_q;

endmodule

// File: tb/tb_sd_dma.sv
// Self-checking bench for sd_dma: randomized transfers against a word-level model.
module tb_sd_dma;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [3:0]  i_dma_bank;
  logic [23:0] i_dma_address;
  logic [14:0] i_dma_length;
  logic        i_load_bank_address, i_load_length, i_direction, i_start, i_stop;
  logic [3:0]  o_dma_bank;
  logic [23:0] o_dma_address;
  logic [14:0] o_dma_left;
  logic        o_busy, o_rx_fifo_pop, i_rx_fifo_empty;
  logic [31:0] i_rx_fifo_data;
  logic        o_tx_fifo_push, i_tx_fifo_full;
  logic [31:0] o_tx_fifo_data;
  logic        o_mem_request, o_mem_write;
  logic [3:0]  o_mem_bank;
  logic [23:0] o_mem_address;
  logic [31:0] o_mem_data;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;

  always #5 clk = ~clk;

  sd_dma dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_dma_bank(i_dma_bank), .i_dma_address(i_dma_address), .i_dma_length(i_dma_length),
    .i_load_bank_address(i_load_bank_address), .i_load_length(i_load_length),
    .i_direction(i_direction), .i_start(i_start), .i_stop(i_stop),
    .o_dma_bank(o_dma_bank), .o_dma_address(o_dma_address), .o_dma_left(o_dma_left),
    .o_busy(o_busy),
    .o_rx_fifo_pop(o_rx_fifo_pop), .i_rx_fifo_empty(i_rx_fifo_empty), .i_rx_fifo_data(i_rx_fifo_data),
    .o_tx_fifo_push(o_tx_fifo_push), .i_tx_fifo_full(i_tx_fifo_full), .o_tx_fifo_data(o_tx_fifo_data),
    .o_mem_request(o_mem_request), .o_mem_write(o_mem_write), .o_mem_bank(o_mem_bank),
    .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Configuration owned by the main sequence.
  int          epoch = 0;
  int          rx_n = 0;
  logic [31:0] rx_words [64];
  int          lat_min = 1, lat_max = 1;
  bit          ack_en = 1'b1, rx_stall_en = 1'b0, tx_full_en = 1'b0, tx_hold_req = 1'b0;
  logic [31:0] mem_seed;

  // State owned by the environment process (FIFOs and memory).
  int          my_epoch, rx_rd, tx_n, log_n, tx_hold, cnt, lat;
  bit          hold_used;
  logic [23:0] a0;
  logic [31:0] tx_got [64];
  logic        log_wr [64];
  logic [3:0]  log_bank [64];
  logic [23:0] log_addr [64];
  logic [31:0] log_data [64];

  function automatic logic [31:0] mem_fn(input logic [3:0] b, input logic [23:0] a);
    return {a, b, 4'hA} ^ mem_seed;
  endfunction

  // Environment: RX FIFO, TX FIFO and memory slave, all driven on the falling edge.
  initial begin
    i_rx_fifo_empty = 1'b1; i_rx_fifo_data = '0; i_tx_fifo_full = 1'b0;
    i_mem_ack = 1'b0; i_mem_data = '0;
    my_epoch = 0; rx_rd = 0; tx_n = 0; log_n = 0; tx_hold = 0; cnt = 0; lat = 1;
    hold_used = 1'b0; a0 = '0;
    forever begin
      @(negedge clk);
      if (epoch != my_epoch) begin
        my_epoch = epoch; rx_rd = 0; tx_n = 0; log_n = 0; tx_hold = 0; cnt = 0;
        hold_used = 1'b0;
        lat = int'($urandom_range(lat_max, lat_min));
      end
      if (o_rx_fifo_pop) rx_rd++;
      i_rx_fifo_empty = (rx_rd >= rx_n) || (rx_stall_en && ($urandom_range(0, 2) == 0));
      i_rx_fifo_data  = rx_words[rx_rd % 64];
      if (o_tx_fifo_push && tx_n < 64) begin
        tx_got[tx_n] = o_tx_fifo_data;
        tx_n++;
      end
      if (tx_hold_req && !hold_used && tx_n == 1) begin
        tx_hold = 5;
        hold_used = 1'b1;
      end
      if (tx_hold > 0) begin
        i_tx_fifo_full = 1'b1;
        tx_hold--;
      end else begin
        i_tx_fifo_full = tx_full_en && ($urandom_range(0, 2) == 0);
      end
      i_mem_ack = 1'b0;
      if (o_mem_request && ack_en) begin
        if (cnt == 0) a0 = o_mem_address;
        cnt++;
        if (cnt >= lat) begin
          check_eq("req_addr_stable", o_mem_address, a0);
          i_mem_ack  = 1'b1;
          i_mem_data = mem_fn(o_mem_bank, o_mem_address);
          if (log_n < 64) begin
            log_wr[log_n] = o_mem_write; log_bank[log_n] = o_mem_bank;
            log_addr[log_n] = o_mem_address; log_data[log_n] = o_mem_data;
            log_n++;
          end
          cnt = 0;
          lat = int'($urandom_range(lat_max, lat_min));
        end
      end else if (!o_mem_request) begin
        cnt = 0;
      end
    end
  end

  task automatic new_epoch(input int n_rx);
    epoch++;
    rx_n = n_rx;
    for (int i = 0; i < 64; i++) rx_words[i] = $urandom;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_cfg(input logic [3:0] bank, input logic [23:0] addr, input int len);
    i_dma_bank = bank; i_dma_address = addr; i_dma_length = 15'(len);
    i_load_bank_address = 1'b1; i_load_length = 1'b1;
    @(negedge clk);
    i_load_bank_address = 1'b0; i_load_length = 1'b0;
  endtask

  // mode 0: plain, 1: load attempt while busy, 2: stop while the first request is up
  task automatic run_xfer(input logic [3:0] bank, input logic [23:0] addr, input int len,
                          input logic dir, input int mode);
    int n, exp_mem, exp_adv;
    logic [23:0] ea;
    new_epoch((dir == 1'b0) ? len : 0);
    load_cfg(bank, addr, len);
    i_direction = dir; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("busy_after_start", o_busy, 1);
    if (mode == 1) load_cfg(~bank, addr ^ 24'h5A5A5A, len + 7);
    if (mode == 2) begin
      n = 0;
      while (!o_mem_request && n < 200) begin @(negedge clk); n++; end
      check_eq("req_before_stop", o_mem_request, 1);
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;
    end
    n = 0;
    while (o_busy && n < 3000) begin @(negedge clk); n++; end
    check_eq("busy_falls", o_busy, 0);
    repeat (2) @(negedge clk);
    exp_mem = (mode == 2) ? 1 : len;
    exp_adv = (mode == 2 && dir == 1'b1) ? 0 : exp_mem;
    check_eq("mem_txn_count", log_n, exp_mem);
    for (int i = 0; i < exp_mem && i < log_n; i++) begin
      ea = addr + 24'(i);
      check_eq("txn_write", log_wr[i], (dir == 1'b0));
      check_eq("txn_bank", log_bank[i], bank);
      check_eq("txn_addr", log_addr[i], ea);
      if (dir == 1'b0) check_eq("txn_wdata", log_data[i], rx_words[i]);
    end
    if (dir == 1'b0) begin
      check_eq("rx_pops", rx_rd, exp_adv);
    end else begin
      check_eq("tx_push_count", tx_n, exp_adv);
      for (int i = 0; i < exp_adv && i < tx_n; i++) begin
        ea = addr + 24'(i);
        check_eq("tx_data", tx_got[i], mem_fn(bank, ea));
      end
    end
    ea = addr + 24'(exp_adv);
    check_eq("final_left", o_dma_left, 15'(len - exp_adv));
    check_eq("final_addr", o_dma_address, ea);
    check_eq("final_bank", o_dma_bank, bank);
  endtask

  initial begin
    logic [23:0] ra;
    int n;
    mem_seed = $urandom;
    i_reset_n = 1'b0; i_dma_bank = '0; i_dma_address = '0; i_dma_length = '0;
    i_load_bank_address = 1'b0; i_load_length = 1'b0; i_direction = 1'b0;
    i_start = 1'b0; i_stop = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_req", o_mem_request, 0);
    check_eq("rst_left", o_dma_left, 0);
    check_eq("rst_addr", o_dma_address, 0);
    check_eq("rst_pop_push", {o_rx_fifo_pop, o_tx_fifo_push, o_mem_write}, 0);
    i_reset_n = 1'b1;
    @(negedge clk);

    // RX to memory, 4 words, ack one cycle after request
    lat_min = 1; lat_max = 1;
    run_xfer(4'd3, 24'h000010, 4, 1'b0, 0);
    // memory to TX, latency 3, TX full for 5 cycles after the first push
    lat_min = 3; lat_max = 3; tx_hold_req = 1'b1;
    run_xfer(4'd3, 24'h000010, 3, 1'b1, 0);
    tx_hold_req = 1'b0;
    // address wrap in both directions
    lat_min = 1; lat_max = 2;
    run_xfer(4'd5, 24'hFFFFFF, 2, 1'b0, 0);
    run_xfer(4'd7, 24'hFFFFFE, 3, 1'b1, 0);
    // load attempts while busy are ignored
    run_xfer(4'd6, 24'h000200, 3, 1'b0, 1);
    // stop while the request is up
    lat_min = 3; lat_max = 3;
    run_xfer(4'd2, 24'h000040, 5, 1'b0, 2);
    run_xfer(4'd2, 24'h000080, 5, 1'b1, 2);

    // start with zero length
    new_epoch(4);
    load_cfg(4'd1, 24'h000300, 0);
    i_direction = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq("len0_busy", o_busy, 0);
    repeat (6) @(negedge clk);
    check_eq("len0_txns", log_n, 0);
    check_eq("len0_pops", rx_rd, 0);

    // start and stop together
    new_epoch(4);
    load_cfg(4'd1, 24'h000300, 3);
    i_direction = 1'b0; i_start = 1'b1; i_stop = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_stop = 1'b0;
    check_eq("startstop_busy", o_busy, 0);
    repeat (6) @(negedge clk);
    check_eq("startstop_txns", log_n, 0);
    check_eq("startstop_left", o_dma_left, 3);

    // randomized transfers with FIFO back-pressure
    for (int t = 0; t < 10; t++) begin
      lat_min = 1; lat_max = int'($urandom_range(1, 4));
      rx_stall_en = $urandom_range(0, 1) == 1;
      tx_full_en  = $urandom_range(0, 1) == 1;
      ra = ($urandom_range(0, 2) == 0) ? (24'hFFFFF8 + 24'($urandom_range(0, 7))) : 24'($urandom);
      run_xfer(4'($urandom), ra, int'($urandom_range(1, 12)), 1'($urandom),
               int'($urandom_range(0, 1)));
    end
    rx_stall_en = 1'b0; tx_full_en = 1'b0;

    // reset while a read request is outstanding
    ack_en = 1'b0;
    new_epoch(0);
    load_cfg(4'd9, 24'h000100, 4);
    i_direction = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!o_mem_request && n < 50) begin @(negedge clk); n++; end
    check_eq("req_before_reset", o_mem_request, 1);
    i_reset_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_req", o_mem_request, 0);
    check_eq("midrst_busy", o_busy, 0);
    check_eq("midrst_left", o_dma_left, 0);
    check_eq("midrst_addr", o_dma_address, 0);
    check_eq("midrst_bank", o_dma_bank, 0);
    check_eq("midrst_write", o_mem_write, 0);
    i_reset_n = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
